// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// LO gets the quotient and HI gets the remainder. The unit stalls the pipeline
// through div_halt while it works. It then presents the result with a one-cycle
// done pulse. All operands take the same latency, including zero and divide-by-zero.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             signed_en,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             div_halt,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] aq;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] aq_next;
  logic             qbit;

  // DIV works on magnitudes; the signs are restored when the result is written.
  assign abs_a = (signed_en && op_a[WIDTH-1]) ? -op_a : op_a;
  assign abs_b = (signed_en && op_b[WIDTH-1]) ? -op_b : op_b;

  // One restoring step. aq starts as the dividend and fills with quotient bits from the right.
  // The shifted partial remainder is one bit wider than an operand so the compare cannot overflow.
  always_comb begin
    rem_shift = {rem, aq[WIDTH-1]};
    qbit      = (rem_shift >= {1'b0, divisor});
    rem_next  = qbit ? (rem_shift[WIDTH-1:0] - divisor) : rem_shift[WIDTH-1:0];
    aq_next   = {aq[WIDTH-2:0], qbit};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state plus stall and done. Flush wins over everything. DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    div_halt  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (en && !flush) begin
          state_nxt = BUSY;
          div_halt  = 1'b1;
        end
      end
      BUSY: begin
        div_halt = 1'b1;
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Datapath: capture operands on accept, iterate while busy, and write signed results on the last step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt       <= '0;
      aq        <= '0;
      divisor   <= '0;
      rem       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            aq      <= abs_a;
            divisor <= abs_b;
            rem     <= '0;
            cnt     <= CW'(WIDTH);
            neg_q   <= signed_en & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_r   <= signed_en & op_a[WIDTH-1];
          end
        end
        BUSY: begin
          aq  <= aq_next;
          rem <= rem_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient  <= neg_q ? -aq_next : aq_next;
            remainder <= neg_r ? -rem_next : rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed tests for div_unit covering DIV/DIVU results, fixed latency,
// stall behaviour, divide-by-zero, overflow, flush and mid-operation reset.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        en;
  logic        signed_en;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        div_halt;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int total;
  int bad;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .en(en), .signed_en(signed_en), .flush(flush),
    .op_a(op_a), .op_b(op_b), .div_halt(div_halt), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one divide. Reports the done latency in cycles after accept, or -1 on timeout.
  // Also reports the result and how many cycles div_halt was wrong. The operands are
  // scrambled once the unit is busy. en stays high through the DONE cycle.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q, output logic [31:0] r,
                        output int halt_err);
    @(posedge clk); #1;
    en = 1'b1; signed_en = s; op_a = a; op_b = b;
    lat = -1; q = '0; r = '0; halt_err = 0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        op_a = ~a; op_b = b ^ 32'h5; signed_en = ~s;
      end
      if (done) begin
        lat = c; q = quotient; r = remainder;
        if (div_halt) halt_err++;
      end else if (!div_halt) begin
        halt_err++;
      end
    end
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // Checks the values held during reset and the stall output after reset is released.
  task automatic test_reset();
    @(negedge clk);
    total++; if (quotient !== 32'h0) begin bad++; $display("[TB] FAIL reset_q: got %h want 0", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("[TB] FAIL reset_r: got %h want 0", remainder); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    total++; if (div_halt !== 1'b0) begin bad++; $display("[TB] FAIL reset_halt: got %b want 0", div_halt); end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    total++; if (div_halt !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset: halt=%b done=%b want 0 0", div_halt, done); end
  endtask

  // Runs a table of divides and checks latency, result, stall and the return to idle.
  task automatic test_arith(input string tag, input logic s, input int n,
                            input logic [31:0] va[8], input logic [31:0] vb[8],
                            input logic [31:0] vq[8], input logic [31:0] vr[8]);
    int lat, herr;
    logic [31:0] q, r;
    for (int i = 0; i < n; i++) begin
      do_div(s, va[i], vb[i], lat, q, r, herr);
      total++; if (lat !== 33) begin bad++; $display("[TB] FAIL %s[%0d]_latency: got %0d want 33", tag, i, lat); end
      total++; if (q !== vq[i]) begin bad++; $display("[TB] FAIL %s[%0d]_quotient: got %h want %h", tag, i, q, vq[i]); end
      total++; if (r !== vr[i]) begin bad++; $display("[TB] FAIL %s[%0d]_remainder: got %h want %h", tag, i, r, vr[i]); end
      total++; if (herr !== 0) begin bad++; $display("[TB] FAIL %s[%0d]_halt: got %0d wrong cycles want 0", tag, i, herr); end
      @(negedge clk);
      total++; if (done !== 1'b0 || div_halt !== 1'b0) begin bad++; $display("[TB] FAIL %s[%0d]_no_reissue: done=%b halt=%b want 0 0", tag, i, done, div_halt); end
    end
  endtask

  // Checks DIVU cases, including all-ones, zero dividend and divide-by-zero.
  task automatic test_unsigned();
    logic [31:0] va[8] = '{32'd100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd0, 32'd9, 32'd0, 32'd0};
    logic [31:0] vb[8] = '{32'd7,   32'd1,        32'd10,       32'd0, 32'd5, 32'd3, 32'd0, 32'd0};
    logic [31:0] vq[8] = '{32'd14,  32'hFFFFFFFF, 32'h19999999, 32'hFFFFFFFF, 32'd0, 32'd3, 32'd0, 32'd0};
    logic [31:0] vr[8] = '{32'd2,   32'd0,        32'd5,        32'd5, 32'd0, 32'd0, 32'd0, 32'd0};
    test_arith("divu", 1'b0, 6, va, vb, vq, vr);
  endtask

  // Checks DIV cases: mixed signs, both negative, overflow and signed divide-by-zero.
  task automatic test_signed();
    logic [31:0] va[8] = '{32'hFFFFFFF9, 32'd7,        32'hFFFFFF9C, 32'h80000000, 32'hFFFFFFFB, 32'd0, 32'd0, 32'd0};
    logic [31:0] vb[8] = '{32'd2,        32'hFFFFFFFE, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd0,        32'd0, 32'd0, 32'd0};
    logic [31:0] vq[8] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd14,       32'h80000000, 32'd1,        32'd0, 32'd0, 32'd0};
    logic [31:0] vr[8] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 32'd0,        32'hFFFFFFFB, 32'd0, 32'd0, 32'd0};
    test_arith("div", 1'b1, 5, va, vb, vq, vr);
  endtask

  // Flushes in BUSY cycle 10. The unit must go idle with the old result kept and no done pulse.
  // The next divide must then work normally.
  task automatic test_flush();
    int lat, herr, pulses;
    logic [31:0] q, r;
    do_div(1'b0, 32'd50, 32'd7, lat, q, r, herr);
    total++; if (q !== 32'd7 || r !== 32'd1) begin bad++; $display("[TB] FAIL flush_pre: got q=%h r=%h want 7 1", q, r); end
    @(posedge clk); #1;
    en = 1'b1; signed_en = 1'b0; op_a = 32'd1000; op_b = 32'd7;
    for (int c = 0; c <= 10; c++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; en = 1'b0;
    @(negedge clk);
    total++; if (div_halt !== 1'b0) begin bad++; $display("[TB] FAIL flush_halt: got %b want 0", div_halt); end
    total++; if (quotient !== 32'd7 || remainder !== 32'd1) begin bad++; $display("[TB] FAIL flush_hold: got q=%h r=%h want 7 1", quotient, remainder); end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL flush_no_done: got %0d pulses want 0", pulses); end
    do_div(1'b0, 32'd9, 32'd3, lat, q, r, herr);
    total++; if (lat !== 33 || q !== 32'd3 || r !== 32'd0) begin bad++; $display("[TB] FAIL flush_next: got lat=%0d q=%h r=%h want 33 3 0", lat, q, r); end
  endtask

  // Asserts reset in BUSY cycle 20. Every output must return to its reset value.
  // The unit must also divide correctly afterwards.
  task automatic test_reset_mid_op();
    int lat, herr;
    logic [31:0] q, r;
    @(posedge clk); #1;
    en = 1'b1; signed_en = 1'b1; op_a = 32'hFFFFFFF9; op_b = 32'd2;
    for (int c = 0; c <= 20; c++) @(negedge clk);
    resetn = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    total++; if (quotient !== 32'h0 || remainder !== 32'h0) begin bad++; $display("[TB] FAIL midreset_result: got q=%h r=%h want 0 0", quotient, remainder); end
    total++; if (done !== 1'b0 || div_halt !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ctrl: done=%b halt=%b want 0 0", done, div_halt); end
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, lat, q, r, herr);
    total++; if (lat !== 33 || q !== 32'hFFFFFFFD || r !== 32'd1) begin bad++; $display("[TB] FAIL midreset_next: got lat=%0d q=%h r=%h want 33 fffffffd 1", lat, q, r); end
  endtask

  // Issues two divides back to back. Each result must be independent of the previous one.
  task automatic test_back_to_back();
    int lat1, lat2, h1, h2;
    logic [31:0] q1, r1, q2, r2;
    do_div(1'b0, 32'd1000, 32'd33, lat1, q1, r1, h1);
    do_div(1'b1, 32'hFFFFFC18, 32'd33, lat2, q2, r2, h2);
    total++; if (lat1 !== 33 || q1 !== 32'd30 || r1 !== 32'd10 || h1 !== 0) begin bad++; $display("[TB] FAIL b2b_first: got lat=%0d q=%h r=%h herr=%0d want 33 1e a 0", lat1, q1, r1, h1); end
    total++; if (lat2 !== 33 || q2 !== 32'hFFFFFFE2 || r2 !== 32'hFFFFFFF6 || h2 !== 0) begin bad++; $display("[TB] FAIL b2b_second: got lat=%0d q=%h r=%h herr=%0d want 33 ffffffe2 fffffff6 0", lat2, q2, r2, h2); end
  endtask

  // Runs the test sequence.
  initial begin
    total = 0; bad = 0;
    resetn = 1'b0; en = 1'b0; signed_en = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
